// File: rtl/rxd_pkg.sv
// Shared types and constants for the ingress frame dispatcher.
// Stage layout, route encoding and the header-field constants used by classifier and top.
package rxd_pkg;

    localparam int unsigned HDR_LEN = 14;

    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETYPE_ARP  = 16'h0806;
    localparam logic [47:0] MAC_BCAST  = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ROUTE_DROP,
        ROUTE_FAST,
        ROUTE_CPU
    } route_t;

    typedef enum logic {
        ST_IDLE,
        ST_ROUTED
    } frame_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       last;
        logic       user;
        logic       sof;
    } stage_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == '1) ? x : x + 32'd1;
    endfunction

endpackage

// File: rtl/rxd_classifier.sv
// Combinational header classifier: picks FAST/CPU/DROP from the 14 held header bytes.
// Index 13 is the oldest stage (first wire byte), index 0 the newest.
module rxd_classifier
    import rxd_pkg::*;
(
    input  logic [HDR_LEN-1:0][7:0] hdr_data,
    input  logic [HDR_LEN-1:0]      hdr_valid,
    input  logic [HDR_LEN-1:1]      hdr_last,
    input  logic                    cfg_enable,
    input  logic [47:0]             cfg_mac,
    input  logic                    cfg_promisc,
    output route_t                  route
);

    logic [47:0] dst;
    logic [15:0] etype;
    logic        header_ok;
    logic        addr_ok;

    always_comb begin
        dst = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            dst[8*i +: 8] = hdr_data[8+i];
        end
        etype     = {hdr_data[1], hdr_data[0]};
        header_ok = (&hdr_valid) && !(|hdr_last);
        addr_ok   = (dst == cfg_mac) || (dst == MAC_BCAST) || cfg_promisc;

        route = ROUTE_DROP;
        if (cfg_enable && header_ok && addr_ok) begin
            if (etype == ETYPE_IPV4) begin
                route = ROUTE_FAST;
            end else if (etype == ETYPE_ARP) begin
                route = ROUTE_CPU;
            end
        end
    end

endmodule

// File: rtl/rx_frame_dispatch.sv
// Ingress dispatcher: 14-stage header delay line, classification at the oldest stage, routed output registers.
// Optional statistics counters are built when RXD_STATS_EN is defined.
module rx_frame_dispatch #(
    parameter int unsigned HDR_LEN = 14
) (
    input  logic        rx_clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        cfg_enable,
    input  logic [47:0] cfg_mac,
    input  logic        cfg_promisc,
    output logic [7:0]  m0_axis_tdata,
    output logic        m0_axis_tvalid,
    output logic        m0_axis_tlast,
    output logic        m0_axis_tuser,
    output logic [7:0]  m1_axis_tdata,
    output logic        m1_axis_tvalid,
    output logic        m1_axis_tlast,
    output logic        m1_axis_tuser
`ifdef RXD_STATS_EN
    ,
    output logic [31:0] stat_fast,
    output logic [31:0] stat_cpu,
    output logic [31:0] stat_drop,
    output logic [31:0] stat_runt
`endif
);

    import rxd_pkg::*;

    stage_t stg [HDR_LEN];
    stage_t head;
    logic   in_frame;

    logic [HDR_LEN-1:0][7:0] hdr_data;
    logic [HDR_LEN-1:0]      hdr_valid;
    logic [HDR_LEN-1:1]      hdr_last;

    route_t       cls_route, route_q, route_d, cur_route;
    frame_state_t state_q, state_d;
    logic         is_sof, is_last, sel0, sel1;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < HDR_LEN; i++) begin
                stg[i] <= '0;
            end
            in_frame <= 1'b0;
        end else begin
            stg[0] <= '{data:  s_axis_tdata,
                        valid: s_axis_tvalid,
                        last:  s_axis_tvalid & s_axis_tlast,
                        user:  s_axis_tvalid & s_axis_tlast & s_axis_tuser,
                        sof:   s_axis_tvalid & ~in_frame};
            for (int unsigned i = 1; i < HDR_LEN; i++) begin
                stg[i] <= stg[i-1];
            end
            if (s_axis_tvalid) begin
                in_frame <= ~s_axis_tlast;
            end
        end
    end

    always_comb begin
        hdr_data  = '0;
        hdr_valid = '0;
        hdr_last  = '0;
        for (int unsigned i = 0; i < HDR_LEN; i++) begin
            hdr_data[i]  = stg[i].data;
            hdr_valid[i] = stg[i].valid;
        end
        for (int unsigned i = 1; i < HDR_LEN; i++) begin
            hdr_last[i] = stg[i].last;
        end
    end

    rxd_classifier u_classifier (
        .hdr_data    (hdr_data),
        .hdr_valid   (hdr_valid),
        .hdr_last    (hdr_last),
        .cfg_enable  (cfg_enable),
        .cfg_mac     (cfg_mac),
        .cfg_promisc (cfg_promisc),
        .route       (cls_route)
    );

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            route_q <= ROUTE_DROP;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    // The sof beat uses the fresh classification; later beats use the latched route.
    always_comb begin
        head      = stg[HDR_LEN-1];
        is_sof    = head.valid & head.sof;
        is_last   = head.valid & head.last;
        state_d   = state_q;
        route_d   = route_q;
        cur_route = (state_q == ST_ROUTED) ? route_q : ROUTE_DROP;
        if (is_sof) begin
            cur_route = cls_route;
            route_d   = cls_route;
            state_d   = ST_ROUTED;
        end
        if (is_last) begin
            route_d = ROUTE_DROP;
            state_d = ST_IDLE;
        end
        sel0 = head.valid && (cur_route == ROUTE_FAST);
        sel1 = head.valid && (cur_route == ROUTE_CPU);
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_axis_tdata  <= '0;
            m0_axis_tvalid <= 1'b0;
            m0_axis_tlast  <= 1'b0;
            m0_axis_tuser  <= 1'b0;
            m1_axis_tdata  <= '0;
            m1_axis_tvalid <= 1'b0;
            m1_axis_tlast  <= 1'b0;
            m1_axis_tuser  <= 1'b0;
        end else begin
            m0_axis_tdata  <= sel0 ? head.data : '0;
            m0_axis_tvalid <= sel0;
            m0_axis_tlast  <= sel0 & head.last;
            m0_axis_tuser  <= sel0 & head.user;
            m1_axis_tdata  <= sel1 ? head.data : '0;
            m1_axis_tvalid <= sel1;
            m1_axis_tlast  <= sel1 & head.last;
            m1_axis_tuser  <= sel1 & head.user;
        end
    end

`ifdef RXD_STATS_EN
    logic runt;

    always_comb begin
        runt = |hdr_last;
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fast <= '0;
            stat_cpu  <= '0;
            stat_drop <= '0;
            stat_runt <= '0;
        end else if (is_sof) begin
            case (cls_route)
                ROUTE_FAST: stat_fast <= sat_inc(stat_fast);
                ROUTE_CPU:  stat_cpu  <= sat_inc(stat_cpu);
                default:    stat_drop <= sat_inc(stat_drop);
            endcase
            if (runt) begin
                stat_runt <= sat_inc(stat_runt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_frame_dispatch.sv
// Self-checking bench for rx_frame_dispatch: frame-level vector table, directed corner sequences,
// and randomized traffic scored cycle by cycle against a frame-level reference model.
module tb_rx_frame_dispatch;

    localparam int R_DROP = 0;
    localparam int R_FAST = 1;
    localparam int R_CPU  = 2;
    localparam int N      = 16384;
    localparam logic [47:0] MY_MAC = 48'h0200_0000_0001;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER  = 48'h0200_0000_0099;

    logic        rx_clk = 1'b0;
    logic        rst_n  = 1'b1;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        cfg_enable;
    logic [47:0] cfg_mac;
    logic        cfg_promisc;
    logic [7:0]  m0_axis_tdata, m1_axis_tdata;
    logic        m0_axis_tvalid, m0_axis_tlast, m0_axis_tuser;
    logic        m1_axis_tvalid, m1_axis_tlast, m1_axis_tuser;
`ifdef RXD_STATS_EN
    logic [31:0] stat_fast, stat_cpu, stat_drop, stat_runt;
`endif

    rx_frame_dispatch #(.HDR_LEN(14)) dut (
        .rx_clk         (rx_clk),
        .rst_n          (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .cfg_enable     (cfg_enable),
        .cfg_mac        (cfg_mac),
        .cfg_promisc    (cfg_promisc),
        .m0_axis_tdata  (m0_axis_tdata),
        .m0_axis_tvalid (m0_axis_tvalid),
        .m0_axis_tlast  (m0_axis_tlast),
        .m0_axis_tuser  (m0_axis_tuser),
        .m1_axis_tdata  (m1_axis_tdata),
        .m1_axis_tvalid (m1_axis_tvalid),
        .m1_axis_tlast  (m1_axis_tlast),
        .m1_axis_tuser  (m1_axis_tuser)
`ifdef RXD_STATS_EN
        ,
        .stat_fast      (stat_fast),
        .stat_cpu       (stat_cpu),
        .stat_drop      (stat_drop),
        .stat_runt      (stat_runt)
`endif
    );

    always #4 rx_clk = ~rx_clk;

    // Per-cycle record of everything driven, indexed by input cycle.
    logic        in_v [N];
    logic        in_l [N];
    logic        in_u [N];
    logic        in_sof [N];
    logic [7:0]  in_d [N];
    int          flen [N];
    logic        en_a [N];
    logic        pr_a [N];
    logic [47:0] mac_a [N];

    int   cyc = 0;
    int   base = 0;
    int   m_route = R_DROP;
    logic mf_in = 1'b0;
    int   m_fast = 0, m_cpu = 0, m_drop = 0, m_runt = 0;
    int   passed = 0, total = 0;
    int   obs0, obs1, first0, last1, first0_after;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Frame-level routing rule applied to the frame whose first byte was driven in cycle k.
    function automatic int route_of(input int k);
        logic        ok = 1'b1;
        logic [47:0] dst = '0;
        logic [15:0] et;
        logic        addr;
        for (int i = 0; i < 14; i++) begin
            if (!in_v[k+i]) ok = 1'b0;
            if (i < 13 && in_l[k+i]) ok = 1'b0;
        end
        for (int i = 0; i < 6; i++) dst = {dst[39:0], in_d[k+i]};
        et   = {in_d[k+12], in_d[k+13]};
        addr = (dst == mac_a[k+14]) || (dst == BCAST) || pr_a[k+14];
        if (!en_a[k+14] || !ok || !addr) return R_DROP;
        if (et == 16'h0800) return R_FAST;
        if (et == 16'h0806) return R_CPU;
        return R_DROP;
    endfunction

    task automatic check();
        int         k = cyc - 15;
        logic       ev0 = 1'b0, ev1 = 1'b0, el = 1'b0, eu = 1'b0;
        logic [7:0] ed = '0;
        if (k >= base) begin
            if (in_v[k]) begin
                if (in_sof[k]) begin
                    m_route = route_of(k);
                    if (m_route == R_FAST) m_fast++;
                    else if (m_route == R_CPU) m_cpu++;
                    else m_drop++;
                    if (flen[k] < 14) m_runt++;
                end
                ev0 = (m_route == R_FAST);
                ev1 = (m_route == R_CPU);
                ed  = in_d[k];
                el  = in_l[k];
                eu  = in_l[k] & in_u[k];
                if (in_l[k]) m_route = R_DROP;
            end
        end
        cmp("m0_beat", {53'd0, m0_axis_tvalid, m0_axis_tvalid ? {m0_axis_tlast, m0_axis_tuser, m0_axis_tdata} : 10'd0},
                       {53'd0, ev0, ev0 ? {el, eu, ed} : 10'd0});
        cmp("m1_beat", {53'd0, m1_axis_tvalid, m1_axis_tvalid ? {m1_axis_tlast, m1_axis_tuser, m1_axis_tdata} : 10'd0},
                       {53'd0, ev1, ev1 ? {el, eu, ed} : 10'd0});
        cmp("no_overlap", {63'd0, m0_axis_tvalid & m1_axis_tvalid}, 64'd0);
`ifdef RXD_STATS_EN
        cmp("stat_fast_cpu", {stat_fast, stat_cpu}, {m_fast[31:0], m_cpu[31:0]});
        cmp("stat_drop_runt", {stat_drop, stat_runt}, {m_drop[31:0], m_runt[31:0]});
`endif
        if (m0_axis_tvalid) begin
            obs0++;
            if (first0 < 0) first0 = cyc;
            if (last1 >= 0 && first0_after < 0) first0_after = cyc;
        end
        if (m1_axis_tvalid) begin
            obs1++;
            if (m1_axis_tlast) last1 = cyc;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic u, input int len);
        if (cyc >= N - 1) begin
            $display("FAIL capacity: cycle %0d exceeds record size %0d", cyc, N);
            $fatal(1);
        end
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        in_v[cyc]  = v;
        in_d[cyc]  = d;
        in_l[cyc]  = v & l;
        in_u[cyc]  = u;
        en_a[cyc]  = cfg_enable;
        pr_a[cyc]  = cfg_promisc;
        mac_a[cyc] = cfg_mac;
        in_sof[cyc] = v & ~mf_in;
        flen[cyc]   = len;
        if (v) mf_in = ~l;
        @(posedge rx_clk);
        #1;
        cyc++;
        check();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0, 0);
    endtask

    // stop_at < len truncates the frame after stop_at bytes (no tlast); flip_at toggles cfg_enable before that byte.
    task automatic send_frame(input int len, input logic [47:0] dst, input logic [15:0] et, input logic u,
                              input int gap_pct, input int flip_at, input int stop_at);
        logic [7:0] b;
        for (int i = 0; i < len && i < stop_at; i++) begin
            if (i < 6) b = dst[8*(5-i) +: 8];
            else if (i == 12) b = et[15:8];
            else if (i == 13) b = et[7:0];
            else b = 8'($urandom);
            if (i == flip_at) cfg_enable = ~cfg_enable;
            if (i > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
            step(1'b1, b, i == len - 1, u && (i == len - 1), len);
        end
    endtask

    task automatic clear_mon();
        obs0 = 0; obs1 = 0; first0 = -1; last1 = -1; first0_after = -1;
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tdata  = 8'h00;
        rst_n = 1'b0;
        m_fast = 0; m_cpu = 0; m_drop = 0; m_runt = 0;
        #1;
        cmp("reset_outputs", {30'd0, m0_axis_tvalid, m0_axis_tlast, m0_axis_tuser, m0_axis_tdata,
                              m1_axis_tvalid, m1_axis_tlast, m1_axis_tuser, m1_axis_tdata}, 64'd0);
`ifdef RXD_STATS_EN
        cmp("reset_stats", {stat_fast, stat_cpu}, 64'd0);
        cmp("reset_stats2", {stat_drop, stat_runt}, 64'd0);
`endif
        repeat (2) begin
            @(posedge rx_clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
        base = cyc;
        mf_in = 1'b0;
        m_route = R_DROP;
    endtask

    typedef struct {
        int          len;
        logic [47:0] dst;
        logic [15:0] et;
        logic        user;
        logic        promisc;
        logic        en;
        int          exp_route;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int e0, e1, t_in, len2;
        tbl[0]  = '{64, MY_MAC, 16'h0800, 1'b0, 1'b0, 1'b1, R_FAST};
        tbl[1]  = '{60, BCAST,  16'h0806, 1'b0, 1'b0, 1'b1, R_CPU};
        tbl[2]  = '{10, MY_MAC, 16'h0800, 1'b0, 1'b0, 1'b1, R_DROP};
        tbl[3]  = '{64, OTHER,  16'h0800, 1'b0, 1'b0, 1'b1, R_DROP};
        tbl[4]  = '{64, OTHER,  16'h0800, 1'b0, 1'b1, 1'b1, R_FAST};
        tbl[5]  = '{20, MY_MAC, 16'h0806, 1'b0, 1'b1, 1'b1, R_CPU};
        tbl[6]  = '{14, MY_MAC, 16'h0800, 1'b0, 1'b0, 1'b1, R_FAST};
        tbl[7]  = '{13, MY_MAC, 16'h0800, 1'b0, 1'b0, 1'b1, R_DROP};
        tbl[8]  = '{40, MY_MAC, 16'h86DD, 1'b0, 1'b0, 1'b1, R_DROP};
        tbl[9]  = '{30, BCAST,  16'h0800, 1'b0, 1'b0, 1'b0, R_DROP};
        tbl[10] = '{30, MY_MAC, 16'h0800, 1'b1, 1'b0, 1'b1, R_FAST};
        tbl[11] = '{30, OTHER,  16'h0806, 1'b0, 1'b0, 1'b1, R_DROP};

        cfg_mac = MY_MAC;
        cfg_enable = 1'b1;
        cfg_promisc = 1'b0;
        clear_mon();
        do_reset();

        for (int i = 0; i < 12; i++) begin
            cfg_promisc = tbl[i].promisc;
            cfg_enable  = tbl[i].en;
            clear_mon();
            t_in = cyc;
            send_frame(tbl[i].len, tbl[i].dst, tbl[i].et, tbl[i].user, 0, -1, 1 << 20);
            idle(20);
            e0 = (tbl[i].exp_route == R_FAST) ? tbl[i].len : 0;
            e1 = (tbl[i].exp_route == R_CPU)  ? tbl[i].len : 0;
            cmp($sformatf("vec%0d_port_beats", i), {obs0[31:0], obs1[31:0]}, {e0[31:0], e1[31:0]});
            if (i == 0) cmp("latency_first_byte", 64'(first0 - t_in), 64'd15);
        end

        // Broadcast ARP followed back-to-back by IPv4 unicast.
        cfg_enable = 1'b1;
        cfg_promisc = 1'b0;
        clear_mon();
        len2 = 48;
        send_frame(60, BCAST, 16'h0806, 1'b0, 0, -1, 1 << 20);
        send_frame(len2, MY_MAC, 16'h0800, 1'b0, 0, -1, 1 << 20);
        idle(20);
        cmp("b2b_beats", {obs0[31:0], obs1[31:0]}, {len2[31:0], 32'd60});
        cmp("b2b_switch_gap", 64'(first0_after - last1), 64'd1);

        // Enable dropped mid-payload of A: A completes, B is dropped.
        clear_mon();
        send_frame(64, MY_MAC, 16'h0800, 1'b0, 0, 30, 1 << 20);
        send_frame(40, MY_MAC, 16'h0800, 1'b0, 0, -1, 1 << 20);
        idle(20);
        cmp("enable_off_midframe", {obs0[31:0], obs1[31:0]}, {32'd64, 32'd0});
        cfg_enable = 1'b1;

        // Gap after the header keeps the frame; gap inside the header drops it.
        clear_mon();
        send_frame(20, MY_MAC, 16'h0800, 1'b0, 0, -1, 16);
        idle(2);
        send_frame(20, MY_MAC, 16'h0800, 1'b0, 0, -1, 1 << 20);
        idle(20);
        clear_mon();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) idle(1);
            step(1'b1, (i < 6) ? MY_MAC[8*(5-i) +: 8] : (i == 12) ? 8'h08 : 8'h00, i == 19, 1'b0, 20);
        end
        idle(20);
        cmp("gap_in_header_dropped", {obs0[31:0], obs1[31:0]}, 64'd0);

        // Reset while a routed frame is mid-flight, then a clean frame.
        clear_mon();
        send_frame(64, MY_MAC, 16'h0800, 1'b0, 0, -1, 30);
        cmp("pre_reset_emitting", {63'd0, m0_axis_tvalid}, 64'd1);
        do_reset();
        clear_mon();
        send_frame(32, MY_MAC, 16'h0800, 1'b0, 0, -1, 1 << 20);
        idle(20);
        cmp("post_reset_frame", {obs0[31:0], obs1[31:0]}, {32'd32, 32'd0});

        // Randomized traffic against the reference model.
        for (int f = 0; f < 40; f++) begin
            int          len;
            logic [47:0] dst;
            logic [15:0] et;
            int          sel;
            len = $urandom_range(5, 80);
            sel = $urandom_range(2);
            dst = (sel == 0) ? MY_MAC : (sel == 1) ? BCAST : OTHER;
            sel = $urandom_range(2);
            et  = (sel == 0) ? 16'h0800 : (sel == 1) ? 16'h0806 : 16'h86DD;
            cfg_promisc = ($urandom_range(3) == 0);
            cfg_enable  = ($urandom_range(7) != 0);
            send_frame(len, dst, et, 1'($urandom), (len >= 14 && $urandom_range(1) == 1) ? 10 : 0,
                       ($urandom_range(3) == 0) ? int'($urandom_range(len - 1)) : -1, 1 << 20);
            idle($urandom_range(3));
        end
        idle(20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
